ps2_kbd_cmd: RTL

Host-to-keyboard command sequencer between the SMC register layer and the PS2 keyboard port. It accepts command bytes written through the SMC "send PS2 keyboard command" register and drives them into the port's TX interface. It then waits for the keyboard's response byte (0xFA ACK / 0xFE RESEND), retrying or timing out as required. A result byte is published for the "read PS2 keyboard status" register, and every other received byte is forwarded to the keyboard scan-code FIFO.

---
 rtl/ps2_kbd_cmd_if.sv | 27 ++
 rtl/ps2_kbd_cmd.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_cmd_if.sv
// Handshake bundle between the SMC command register, the PS2 keyboard port and the scan-code FIFO.
// slave is the command sequencer side; master is the surrounding logic that drives its inputs.
interface ps2_kbd_cmd_if;
   logic [7:0] cmd_i;
   logic       cmd_v_i;
   logic       cmd_busy_o;
   logic [7:0] stat_o;
   logic [7:0] ps2_tx_o;
   logic       ps2_tx_v_o;
   logic       ps2_busy_i;
   logic       ps2_tx_acked_i;
   logic       ps2_tx_errd_i;
   logic [7:0] rx_code_i;
   logic       rx_code_v_i;
   logic [7:0] fwd_code_o;
   logic       fwd_code_v_o;

   modport slave (
      input  cmd_i, cmd_v_i, ps2_busy_i, ps2_tx_acked_i, ps2_tx_errd_i, rx_code_i, rx_code_v_i,
      output cmd_busy_o, stat_o, ps2_tx_o, ps2_tx_v_o, fwd_code_o, fwd_code_v_o
   );

   modport master (
      output cmd_i, cmd_v_i, ps2_busy_i, ps2_tx_acked_i, ps2_tx_errd_i, rx_code_i, rx_code_v_i,
      input  cmd_busy_o, stat_o, ps2_tx_o, ps2_tx_v_o, fwd_code_o, fwd_code_v_o
   );
endinterface

// File: rtl/ps2_kbd_cmd.sv
// Host-to-keyboard command sequencer: sends a command byte, waits for ACK/RESEND with retry and
// timeout, forwards unrelated bytes. Define PS2KBD_CMD_RESPFWD_EN to also forward consumed responses.
module ps2_kbd_cmd #(
   parameter int unsigned TIMEOUT_US = 20000,
   parameter int unsigned MAX_RETRY  = 2
) (
   input  logic          clk6x,
   input  logic          resetn,
   input  logic          ck1us,
   ps2_kbd_cmd_if.slave  bus
);

   localparam int unsigned TmoW   = $clog2(TIMEOUT_US + 1);
   localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [TmoW-1:0]   TmoMax   = TmoW'(TIMEOUT_US);
   localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_US - 1);
   localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

   localparam logic [7:0] RespAck    = 8'hFA;
   localparam logic [7:0] RespResend = 8'hFE;
   localparam logic [7:0] StatNone   = 8'h00;
   localparam logic [7:0] StatTmo    = 8'hFF;

`ifdef PS2KBD_CMD_RESPFWD_EN
   localparam bit RespFwd = 1'b1;
`else
   localparam bit RespFwd = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StSend, StWaitLink, StWaitResp} state_e;

   state_e            state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [7:0]        stat_q, stat_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [7:0]        tx_q, tx_d;
   logic              tx_v_q, tx_v_d;
   logic [7:0]        fwd_q, fwd_d;
   logic              fwd_v_q, fwd_v_d;

   logic              retry_req;
   logic              tmo_hit;
   logic              is_resp;
   logic [TmoW-1:0]   tmo_inc;

   // Timeout fires on the tick that brings the count to TIMEOUT_US, or once already saturated.
   assign tmo_hit = (tmo_q == TmoMax) || (ck1us && (tmo_q == TmoLast));
   assign tmo_inc = (ck1us && (tmo_q != TmoMax)) ? tmo_q + 1'b1 : tmo_q;
   assign is_resp = (bus.rx_code_i == RespAck) || (bus.rx_code_i == RespResend);

   always_ff @(posedge clk6x) begin
      if (!resetn) begin
         state_q <= StIdle;
         cmd_q   <= 8'h00;
         stat_q  <= StatNone;
         retry_q <= '0;
         tmo_q   <= '0;
         tx_q    <= 8'h00;
         tx_v_q  <= 1'b0;
         fwd_q   <= 8'h00;
         fwd_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         stat_q  <= stat_d;
         retry_q <= retry_d;
         tmo_q   <= tmo_d;
         tx_q    <= tx_d;
         tx_v_q  <= tx_v_d;
         fwd_q   <= fwd_d;
         fwd_v_q <= fwd_v_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      stat_d    = stat_q;
      retry_d   = retry_q;
      tmo_d     = tmo_q;
      tx_d      = tx_q;
      tx_v_d    = 1'b0;
      retry_req = 1'b0;

      case (state_q)
         StIdle: begin
            if (bus.cmd_v_i) begin
               state_d = StSend;
               cmd_d   = bus.cmd_i;
               stat_d  = StatNone;
               retry_d = '0;
            end
         end
         StSend: begin
            if (!bus.ps2_busy_i) begin
               tx_v_d  = 1'b1;
               tx_d    = cmd_q;
               tmo_d   = '0;
               state_d = StWaitLink;
            end
         end
         StWaitLink: begin
            tmo_d = tmo_inc;
            // A NACK wins over a simultaneous ACK.
            if (bus.ps2_tx_errd_i) begin
               retry_req = 1'b1;
            end else if (bus.ps2_tx_acked_i) begin
               tmo_d   = '0;
               state_d = StWaitResp;
            end else if (tmo_hit) begin
               stat_d  = StatTmo;
               state_d = StIdle;
            end
         end
         StWaitResp: begin
            tmo_d = tmo_inc;
            if (bus.rx_code_v_i) begin
               if (bus.rx_code_i == RespAck) begin
                  stat_d  = RespAck;
                  state_d = StIdle;
               end else if (bus.rx_code_i == RespResend) begin
                  retry_req = 1'b1;
               end
            end else if (tmo_hit) begin
               stat_d  = StatTmo;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (retry_req) begin
         if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            state_d = StSend;
         end else begin
            stat_d  = RespResend;
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      fwd_v_d = bus.rx_code_v_i && (RespFwd || !((state_q == StWaitResp) && is_resp));
      fwd_d   = fwd_v_d ? bus.rx_code_i : fwd_q;
   end

   always_comb begin
      bus.cmd_busy_o   = (state_q != StIdle);
      bus.stat_o       = stat_q;
      bus.ps2_tx_o     = tx_q;
      bus.ps2_tx_v_o   = tx_v_q;
      bus.fwd_code_o   = fwd_q;
      bus.fwd_code_v_o = fwd_v_q;
   end

endmodule
